// File: rtl/instrumented_adder_measure_ctrl.sv
// Sequencer for one ring-oscillator timing measurement on the instrumented adder:
// latches operands, gates the ring for a programmed window, counts synchronised chain_out edges.
module instrumented_adder_measure_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [CNT_W-1:0] window_cyc,
    input  logic             chain_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned DRAIN_CYC = 3;
    localparam int unsigned PH_MAX    = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
    localparam int unsigned PH_W      = $clog2(PH_MAX);
    localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] DRAIN_LOAD  = PH_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] win_len_q, win_len_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             ring_en_q, ring_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sync1_q, sync2_q, prev_q;

    logic start_acc_c;
    logic cnt_en_c;
    logic edge_c;

    assign start_acc_c = (state_q == S_IDLE) && start && !abort;
    assign edge_c      = sync2_q & ~prev_q;
    // With a zero window the ring never ran, so the drain phase has nothing to collect.
    assign cnt_en_c    = (state_q == S_RUN) ||
                         ((state_q == S_DRAIN) && (win_len_q != '0));

    // State and datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            win_q     <= '0;
            win_len_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ring_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            win_q     <= win_d;
            win_len_q <= win_len_d;
            a_q       <= a_d;
            b_q       <= b_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ring_en_q <= ring_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sync1_q   <= chain_out;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    // Next-state and phase timers
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                ph_d    = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (ph_q == '0) begin
                    if (win_len_q == '0) begin
                        state_d = S_DRAIN;
                        ph_d    = DRAIN_LOAD;
                    end else begin
                        state_d = S_RUN;
                        win_d   = win_len_q - CNT_W'(1);
                    end
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            S_RUN: begin
                if (win_q == '0) begin
                    state_d = S_DRAIN;
                    ph_d    = DRAIN_LOAD;
                end else begin
                    win_d = win_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (ph_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Registered control outputs follow the state being entered
    always_comb begin
        ring_en_d = (state_d == S_RUN);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // Operand capture and saturating edge counter
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        win_len_d = win_len_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (start_acc_c) begin
            a_d       = a_in;
            b_d       = b_in;
            win_len_d = window_cyc;
            count_d   = '0;
            ovf_d     = 1'b0;
        end else if (cnt_en_c && edge_c) begin
            if (count_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign ring_en  = ring_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_instrumented_adder_measure_ctrl.sv
// Directed bench for instrumented_adder_measure_ctrl: default instance plus a 1-bit counter
// instance for saturation; chain_out comes from a simple ring model or a free toggler.
module tb_instrumented_adder_measure_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] window_cyc = '0;
    logic        chain_out = 1'b0;
    logic [31:0] a_out, b_out, count;
    logic        ring_en, busy, done, overflow;

    instrumented_adder_measure_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start     (start),
        .abort     (abort),
        .a_in      (a_in),
        .b_in      (b_in),
        .window_cyc(window_cyc),
        .chain_out (chain_out),
        .a_out     (a_out),
        .b_out     (b_out),
        .ring_en   (ring_en),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow)
    );

    // Narrow instance: 1-bit counter so saturation is reachable
    logic       start1 = 1'b0;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    logic [0:0] win1 = '0;
    logic       chain1 = 1'b0;
    logic [3:0] a_out1, b_out1;
    logic [0:0] count1;
    logic       ring_en1, busy1, done1, ovf1;

    instrumented_adder_measure_ctrl #(.WIDTH(4), .CNT_W(1), .SETTLE_CYC(1)) dut1 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start     (start1),
        .abort     (1'b0),
        .a_in      (a1),
        .b_in      (b1),
        .window_cyc(win1),
        .chain_out (chain1),
        .a_out     (a_out1),
        .b_out     (b_out1),
        .ring_en   (ring_en1),
        .busy      (busy1),
        .done      (done1),
        .count     (count1),
        .overflow  (ovf1)
    );

    // chain_out source for dut: 0 = held low, 1 = ring toggling every 2 clk while enabled, 2 = free toggle
    int chain_mode = 0;
    int ring_div = 0;
    always @(negedge clk) begin
        if (chain_mode == 1) begin
            if (ring_en) begin
                ring_div = ring_div + 1;
                if (ring_div == 2) begin
                    chain_out = ~chain_out;
                    ring_div  = 0;
                end
            end
        end else if (chain_mode == 2) begin
            chain_out = ~chain_out;
        end else begin
            chain_out = 1'b0;
            ring_div  = 0;
        end
    end

    always @(negedge clk) chain1 = ~chain1;

    int ring_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (ring_en) ring_cnt = ring_cnt + 1;
        if (done)    done_cnt = done_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
        a_in       = a;
        b_in       = b;
        window_cyc = w;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Returns the negedge index (start-drive negedge = 0) at which done is seen; 0 on timeout
    task automatic wait_done(input int budget, input int pulse_at, output int lat);
        lat = 0;
        for (int i = 2; i <= budget; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                start      = 1'b1;
                a_in       = 32'hAA;
                b_in       = 32'hBB;
                window_cyc = 32'd30;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chain_restart();
        chain_mode = 0;
        repeat (2) @(negedge clk);
        chain_mode = 1;
        ring_cnt   = 0;
    endtask

    int lat;
    int d0;
    logic seen;

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_a_out", a_out, 0);
        check("rst_ring_en", ring_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic measurement, window 10
        chain_restart();
        pulse_start(32'd5, 32'd3, 32'd10);
        check("t1_busy_load", busy, 1);
        check("t1_a_out_load", a_out, 5);
        wait_done(60, 0, lat);
        check("t1_latency", lat, 5 + 4 + 10);
        check("t1_count", count, 3);
        check("t1_ovf", overflow, 0);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_ring_cycles", ring_cnt, 10);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_b_out_hold", b_out, 3);
        check("t1_count_hold", count, 3);

        // 2: zero window, chain_out toggling freely
        chain_mode = 2;
        ring_cnt   = 0;
        pulse_start(32'd1, 32'd2, 32'd0);
        wait_done(60, 0, lat);
        check("t2_latency", lat, 5 + 4 + 0);
        check("t2_count", count, 0);
        @(negedge clk);
        check("t2_ring_cycles", ring_cnt, 0);
        check("t2_done_pulses", done_cnt, 2);

        // 3: 1-bit counter saturates and flags overflow
        a1 = 4'd9; b1 = 4'd6; win1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
            if (done1) begin
                lat = i;
                break;
            end
        end
        check("t3_latency", lat, 5 + 1 + 1);
        check("t3_count", count1, 1);
        check("t3_ovf", ovf1, 1);
        check("t3_a_out", a_out1, 9);
        @(negedge clk);
        // Next accepted start clears the sticky overflow
        win1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t3_ovf_cleared", ovf1, 0);
        lat = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
            if (done1) begin
                lat = i;
                break;
            end
        end
        check("t3b_latency", lat, 5 + 1 + 0);
        check("t3b_count", count1, 0);

        // 4: abort during RUN
        chain_restart();
        pulse_start(32'd7, 32'd9, 32'd20);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ring_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_ring_started", seen, 1);
        @(negedge clk);
        d0    = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_ring_off", ring_en, 0);
        check("t4_busy_off", busy, 0);
        repeat (30) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_a_out", a_out, 7);
        check("t4_b_out", b_out, 9);
        // abort and start together in IDLE: abort wins
        a_in = 32'h55; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t4_abort_wins_busy", busy, 0);
        check("t4_abort_wins_a", a_out, 7);

        // 5: start re-pulsed mid-RUN is ignored
        chain_restart();
        pulse_start(32'h11, 32'h22, 32'd6);
        wait_done(60, 8, lat);
        check("t5_latency", lat, 5 + 4 + 6);
        check("t5_a_out", a_out, 32'h11);
        check("t5_b_out", b_out, 32'h22);
        check("t5_count", count, 2);
        @(negedge clk);
        check("t5_ring_cycles", ring_cnt, 6);

        // 6: reset mid-SETTLE clears outputs immediately
        chain_restart();
        pulse_start(32'h33, 32'h44, 32'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_a_out", a_out, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        // reset mid-RUN drops the ring enable at once
        chain_restart();
        pulse_start(32'h66, 32'h77, 32'd8);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ring_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_ring_started", seen, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_ring_en", ring_en, 0);
        check("t6_rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        // fresh measurement after reset
        chain_restart();
        pulse_start(32'd1, 32'd2, 32'd4);
        wait_done(60, 0, lat);
        check("t6_fresh_latency", lat, 5 + 4 + 4);
        check("t6_fresh_count", count, 1);
        check("t6_fresh_a_out", a_out, 1);
        @(negedge clk);
        check("t6_fresh_ring_cycles", ring_cnt, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
